// File: rtl/mips_instruction_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction fetch stage.
// Holds the fetch FSM state encoding and the bus byte-order helper.
package mips_instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] bswap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/mips_instruction_fetch_if.sv
// Avalon-MM read-only instruction bus between the fetch stage and the memory slave.
interface mips_instruction_fetch_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );

endinterface

// File: rtl/mips_instruction_fetch.sv
// Instruction fetch stage: one Avalon-MM read per instruction, holds the word for decode,
// pulses pc_advance once per completed read, and halts on the halt address or a fetch fault.
module mips_instruction_fetch
  import mips_instruction_fetch_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
  parameter bit          BYTE_SWAP  = 1'b1,
  parameter int unsigned WAIT_LIMIT = 32'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    pc,
  input  logic                           fetch_en,
  mips_instruction_fetch_if.master       avm,
  output logic [31:0]                    instr,
  output logic [31:0]                    instr_pc,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic                           pc_advance,
  output logic                           active,
  output logic                           fetch_error
);

  localparam logic [15:0] WAIT_LIMIT_W = WAIT_LIMIT[15:0];

  fetch_state_t state_r;
  fetch_state_t state_nxt_s;
  logic [15:0]  wait_cnt_r;
  logic [15:0]  wait_nxt_s;
  logic [15:0]  wait_inc_s;
  logic [31:0]  addr_nxt_s;
  logic         read_nxt_s;
  logic [31:0]  instr_nxt_s;
  logic [31:0]  ipc_nxt_s;
  logic         valid_nxt_s;
  logic         adv_nxt_s;
  logic         active_nxt_s;
  logic         err_nxt_s;
  logic         try_fetch_s;
  logic [31:0]  rdata_s;

  assign wait_inc_s = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : (wait_cnt_r + 16'd1);
  assign rdata_s    = BYTE_SWAP ? bswap32(avm.avm_readdata) : avm.avm_readdata;

  // Next-state and next-output logic for the fetch FSM
  always_comb begin
    state_nxt_s  = state_r;
    wait_nxt_s   = wait_cnt_r;
    addr_nxt_s   = avm.avm_address;
    read_nxt_s   = avm.avm_read;
    instr_nxt_s  = instr;
    ipc_nxt_s    = instr_pc;
    valid_nxt_s  = instr_valid;
    adv_nxt_s    = 1'b0;
    active_nxt_s = active;
    err_nxt_s    = fetch_error;
    try_fetch_s  = 1'b0;

    case (state_r)
      IDLE: begin
        try_fetch_s = 1'b1;
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          instr_nxt_s = rdata_s;
          ipc_nxt_s   = avm.avm_address;
          valid_nxt_s = 1'b1;
          adv_nxt_s   = 1'b1;
          read_nxt_s  = 1'b0;
          state_nxt_s = HOLD;
        end else begin
          wait_nxt_s = wait_inc_s;
          // Watchdog: abandon the read once the stall budget is spent
          if ((WAIT_LIMIT != 32'd0) && (wait_inc_s >= WAIT_LIMIT_W)) begin
            err_nxt_s    = 1'b1;
            read_nxt_s   = 1'b0;
            active_nxt_s = 1'b0;
            state_nxt_s  = HALT;
          end else begin
            state_nxt_s = REQ;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_nxt_s = 1'b0;
          try_fetch_s = 1'b1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      HALT: begin
        read_nxt_s   = 1'b0;
        valid_nxt_s  = 1'b0;
        active_nxt_s = 1'b0;
      end
      default: begin
        read_nxt_s   = 1'b0;
        valid_nxt_s  = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase

    // Shared IDLE decision, also taken on HOLD exit against the advanced pc
    if (try_fetch_s) begin
      if (pc == HALT_ADDR) begin
        active_nxt_s = 1'b0;
        state_nxt_s  = HALT;
      end else if (pc[1:0] != 2'b00) begin
        err_nxt_s    = 1'b1;
        active_nxt_s = 1'b0;
        state_nxt_s  = HALT;
      end else if (fetch_en) begin
        addr_nxt_s  = pc;
        read_nxt_s  = 1'b1;
        wait_nxt_s  = 16'd0;
        state_nxt_s = REQ;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      try_fetch_s = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r            <= IDLE;
      wait_cnt_r         <= 16'd0;
      avm.avm_address    <= 32'd0;
      avm.avm_read       <= 1'b0;
      avm.avm_byteenable <= 4'b0000;
      instr              <= 32'd0;
      instr_pc           <= 32'd0;
      instr_valid        <= 1'b0;
      pc_advance         <= 1'b0;
      active             <= 1'b1;
      fetch_error        <= 1'b0;
    end else begin
      state_r            <= state_nxt_s;
      wait_cnt_r         <= wait_nxt_s;
      avm.avm_address    <= addr_nxt_s;
      avm.avm_read       <= read_nxt_s;
      avm.avm_byteenable <= read_nxt_s ? 4'b1111 : 4'b0000;
      instr              <= instr_nxt_s;
      instr_pc           <= ipc_nxt_s;
      instr_valid        <= valid_nxt_s;
      pc_advance         <= adv_nxt_s;
      active             <= active_nxt_s;
      fetch_error        <= err_nxt_s;
    end
  end

endmodule
